// File: rtl/intra_ref_addr_gen_if.sv
// Read-address bus between the intra reference address generator and the
// neighbour-RAM arbiter.
//   ADDRESS_RAM : neighbour RAM read address (generator -> arbiter)
//   addr_valid  : ADDRESS_RAM carries a beat this cycle
//   EN_TOP      : beat targets the top/corner bank
//   EN_LEFT     : beat targets the left bank
//   last        : beat is the final one of the sequence
//   rd_ready    : arbiter accepts the presented beat (arbiter -> generator)
interface intra_ref_addr_gen_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] ADDRESS_RAM;
  logic              addr_valid;
  logic              EN_TOP;
  logic              EN_LEFT;
  logic              last;
  logic              rd_ready;

  modport master (
    output ADDRESS_RAM,
    output addr_valid,
    output EN_TOP,
    output EN_LEFT,
    output last,
    input  rd_ready
  );

  modport slave (
    input  ADDRESS_RAM,
    input  addr_valid,
    input  EN_TOP,
    input  EN_LEFT,
    input  last,
    output rd_ready
  );
endinterface

// File: rtl/intra_ref_addr_gen.sv
// Reference-sample address generator for intra prediction.
// On a start pulse in IDLE it latches the block parameters and streams one
// neighbour-RAM address per accepted beat:
//   planar : TOP(N) -> TR -> LEFT(N) -> BL
//   DC     : TOP(N) -> LEFT(N)
//   angular: CORNER -> TOP(2N) -> LEFT(2N)
// Ports:
//   CLK, RST_n        : clock (rising edge), async active-low reset
//   start, abort      : request (IDLE only) / synchronous cancel
//   mode, pu_size     : fetch pattern and log2 PU size code
//   X, Y              : top-row / left-column base addresses
//   TOP_RIGHT,
//   BOTTOM_LEFT       : single-sample addresses used by planar
//   rd (master)       : registered address bus with valid/ready handshake
//   busy, done        : not-IDLE flag, one-cycle completion pulse
module intra_ref_addr_gen #(
  parameter int                ADDR_W      = 8,
  parameter int                COORD_W     = 6,
  parameter logic [ADDR_W-1:0] CORNER_ADDR = {ADDR_W{1'b0}}
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           mode,
  input  logic [2:0]           pu_size,
  input  logic [COORD_W-1:0]   X,
  input  logic [COORD_W-1:0]   Y,
  input  logic [ADDR_W-1:0]    TOP_RIGHT,
  input  logic [ADDR_W-1:0]    BOTTOM_LEFT,
  intra_ref_addr_gen_if.master rd,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] MODE_PLANAR  = 2'd0;
  localparam logic [1:0] MODE_DC      = 2'd1;
  localparam logic [1:0] MODE_ANGULAR = 2'd2;

  // Adder width wide enough for the coordinate, the 7-bit offset and the
  // address, so that truncation to ADDR_W gives the modulo-2^ADDR_W sum.
  localparam int MAX_AC = (ADDR_W > COORD_W) ? ADDR_W : COORD_W;
  localparam int SUM_W  = (MAX_AC > 7) ? MAX_AC : 7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CORNER = 3'd1,
    S_TOP    = 3'd2,
    S_TR     = 3'd3,
    S_LEFT   = 3'd4,
    S_BL     = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t             state_r;
  state_t             nxt_state_s;
  logic [6:0]         off_r;
  logic [6:0]         nxt_off_s;
  logic [6:0]         seg_max_r;
  logic [6:0]         seg_max_s;
  logic [6:0]         n_s;
  logic [1:0]         mode_r;
  logic [1:0]         mode_s;
  logic [COORD_W-1:0] x_r;
  logic [COORD_W-1:0] y_r;
  logic [COORD_W-1:0] nxt_base_s;
  logic [ADDR_W-1:0]  tr_r;
  logic [ADDR_W-1:0]  bl_r;
  logic [ADDR_W-1:0]  nxt_addr_s;
  logic               nxt_top_s;
  logic               nxt_left_s;
  logic               nxt_last_s;
  logic               accept_s;

  // Zero-extended coordinate plus offset, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] coord_plus(input logic [COORD_W-1:0] c,
                                                   input logic [6:0]         o);
    logic [SUM_W-1:0] s;
    s = SUM_W'(c) + SUM_W'(o);
    return s[ADDR_W-1:0];
  endfunction

  assign accept_s = rd.addr_valid && rd.rd_ready;

  // Decode request: normalise mode 3 to DC, clamp size, derive last offset of a run.
  always_comb begin
    mode_s = (mode == 2'd3) ? MODE_DC : mode;
    case (pu_size)
      3'd0:    n_s = 7'd4;
      3'd1:    n_s = 7'd8;
      3'd2:    n_s = 7'd16;
      default: n_s = 7'd32;
    endcase
    seg_max_s = (mode_s == MODE_ANGULAR) ? ((n_s << 1) - 7'd1) : (n_s - 7'd1);
  end

  // Successor of the beat currently presented.
  always_comb begin
    nxt_state_s = state_r;
    nxt_off_s   = off_r;
    case (state_r)
      S_CORNER: begin
        nxt_state_s = S_TOP;
        nxt_off_s   = 7'd0;
      end
      S_TOP: begin
        if (off_r == seg_max_r) begin
          nxt_state_s = (mode_r == MODE_PLANAR) ? S_TR : S_LEFT;
          nxt_off_s   = 7'd0;
        end else begin
          nxt_off_s   = off_r + 7'd1;
        end
      end
      S_TR: begin
        nxt_state_s = S_LEFT;
        nxt_off_s   = 7'd0;
      end
      S_LEFT: begin
        if (off_r == seg_max_r) begin
          nxt_state_s = (mode_r == MODE_PLANAR) ? S_BL : S_DONE;
          nxt_off_s   = 7'd0;
        end else begin
          nxt_off_s   = off_r + 7'd1;
        end
      end
      S_BL: begin
        nxt_state_s = S_DONE;
        nxt_off_s   = 7'd0;
      end
      default: begin
        nxt_state_s = state_r;
        nxt_off_s   = off_r;
      end
    endcase
  end

  // Address, bank enables and last flag for the successor beat.
  always_comb begin
    nxt_base_s = (nxt_state_s == S_TOP) ? x_r : y_r;
    case (nxt_state_s)
      S_CORNER: nxt_addr_s = CORNER_ADDR;
      S_TOP:    nxt_addr_s = coord_plus(nxt_base_s, nxt_off_s);
      S_TR:     nxt_addr_s = tr_r;
      S_LEFT:   nxt_addr_s = coord_plus(nxt_base_s, nxt_off_s);
      S_BL:     nxt_addr_s = bl_r;
      default:  nxt_addr_s = {ADDR_W{1'b0}};
    endcase
    nxt_top_s  = (nxt_state_s == S_CORNER) || (nxt_state_s == S_TOP) || (nxt_state_s == S_TR);
    nxt_left_s = (nxt_state_s == S_LEFT) || (nxt_state_s == S_BL);
    // Planar ends on BL; DC/angular end on the final LEFT sample.
    nxt_last_s = (nxt_state_s == S_BL) ||
                 ((nxt_state_s == S_LEFT) && (nxt_off_s == seg_max_r) &&
                  (mode_r != MODE_PLANAR));
  end

  // Sequencer FSM with registered bus outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r        <= S_IDLE;
      off_r          <= 7'd0;
      seg_max_r      <= 7'd0;
      mode_r         <= 2'd0;
      x_r            <= {COORD_W{1'b0}};
      y_r            <= {COORD_W{1'b0}};
      tr_r           <= {ADDR_W{1'b0}};
      bl_r           <= {ADDR_W{1'b0}};
      rd.ADDRESS_RAM <= {ADDR_W{1'b0}};
      rd.addr_valid  <= 1'b0;
      rd.EN_TOP      <= 1'b0;
      rd.EN_LEFT     <= 1'b0;
      rd.last        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else if (abort) begin
      // Cancel wins over start and over any beat presented this cycle.
      state_r        <= S_IDLE;
      off_r          <= 7'd0;
      rd.ADDRESS_RAM <= {ADDR_W{1'b0}};
      rd.addr_valid  <= 1'b0;
      rd.EN_TOP      <= 1'b0;
      rd.EN_LEFT     <= 1'b0;
      rd.last        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_r        <= mode_s;
            seg_max_r     <= seg_max_s;
            x_r           <= X;
            y_r           <= Y;
            tr_r          <= TOP_RIGHT;
            bl_r          <= BOTTOM_LEFT;
            off_r         <= 7'd0;
            busy          <= 1'b1;
            rd.addr_valid <= 1'b1;
            rd.EN_TOP     <= 1'b1;
            rd.EN_LEFT    <= 1'b0;
            rd.last       <= 1'b0;
            if (mode_s == MODE_ANGULAR) begin
              state_r        <= S_CORNER;
              rd.ADDRESS_RAM <= CORNER_ADDR;
            end else begin
              state_r        <= S_TOP;
              rd.ADDRESS_RAM <= coord_plus(X, 7'd0);
            end
          end else begin
            busy          <= 1'b0;
            rd.addr_valid <= 1'b0;
            rd.EN_TOP     <= 1'b0;
            rd.EN_LEFT    <= 1'b0;
            rd.last       <= 1'b0;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          if (accept_s) begin
            state_r <= nxt_state_s;
            off_r   <= nxt_off_s;
            if (nxt_state_s == S_DONE) begin
              rd.ADDRESS_RAM <= {ADDR_W{1'b0}};
              rd.addr_valid  <= 1'b0;
              rd.EN_TOP      <= 1'b0;
              rd.EN_LEFT     <= 1'b0;
              rd.last        <= 1'b0;
              done           <= 1'b1;
            end else begin
              rd.ADDRESS_RAM <= nxt_addr_s;
              rd.addr_valid  <= 1'b1;
              rd.EN_TOP      <= nxt_top_s;
              rd.EN_LEFT     <= nxt_left_s;
              rd.last        <= nxt_last_s;
              done           <= 1'b0;
            end
          end else begin
            // Stalled: the presented beat holds.
            state_r <= state_r;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intra_ref_addr_gen.sv
// Self-checking bench for intra_ref_addr_gen. Two instances run in lockstep:
// one with ADDR_W=8 and one with ADDR_W=6 (address wrap). Expected beats are
// built per request as a list from the mode/size rules and compared each cycle.
module tb_intra_ref_addr_gen;

  typedef struct {
    int addr;
    bit top;
    bit left;
    bit last;
  } beat_t;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] pu_size = 3'd0;
  logic [5:0] X = 6'd0;
  logic [5:0] Y = 6'd0;
  logic [7:0] TR = 8'd0;
  logic [7:0] BL = 8'd0;
  logic       rd_ready = 1'b1;
  logic       busy_a, done_a, busy_b, done_b;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t q[$];
  beat_t zb = '{0, 1'b0, 1'b0, 1'b0};

  intra_ref_addr_gen_if #(.ADDR_W(8)) bus_a();
  intra_ref_addr_gen_if #(.ADDR_W(6)) bus_b();
  assign bus_a.rd_ready = rd_ready;
  assign bus_b.rd_ready = rd_ready;

  intra_ref_addr_gen #(.ADDR_W(8), .COORD_W(6), .CORNER_ADDR(8'd0)) dut_a (
    .CLK(CLK), .RST_n(RST_n), .start(start), .abort(abort), .mode(mode),
    .pu_size(pu_size), .X(X), .Y(Y), .TOP_RIGHT(TR), .BOTTOM_LEFT(BL),
    .rd(bus_a), .busy(busy_a), .done(done_a));

  intra_ref_addr_gen #(.ADDR_W(6), .COORD_W(6), .CORNER_ADDR(6'd0)) dut_b (
    .CLK(CLK), .RST_n(RST_n), .start(start), .abort(abort), .mode(mode),
    .pu_size(pu_size), .X(X), .Y(Y), .TOP_RIGHT(TR[5:0]), .BOTTOM_LEFT(BL[5:0]),
    .rd(bus_b), .busy(busy_b), .done(done_b));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare both instances against one expected bus state.
  task automatic chk_out(input string tag, input bit v, input beat_t b, input bit d,
                         input bit bz, input bit zaddr);
    chk({tag, " valid_a"}, 32'(bus_a.addr_valid), 32'(v));
    chk({tag, " valid_b"}, 32'(bus_b.addr_valid), 32'(v));
    if (v) begin
      chk({tag, " addr_a"}, 32'(bus_a.ADDRESS_RAM), b.addr & 32'hFF);
      chk({tag, " addr_b"}, 32'(bus_b.ADDRESS_RAM), b.addr & 32'h3F);
    end else if (zaddr) begin
      chk({tag, " addr_a"}, 32'(bus_a.ADDRESS_RAM), 32'd0);
      chk({tag, " addr_b"}, 32'(bus_b.ADDRESS_RAM), 32'd0);
    end
    chk({tag, " en_top_a"},  32'(bus_a.EN_TOP),  32'(v & b.top));
    chk({tag, " en_left_a"}, 32'(bus_a.EN_LEFT), 32'(v & b.left));
    chk({tag, " last_a"},    32'(bus_a.last),    32'(v & b.last));
    chk({tag, " en_top_b"},  32'(bus_b.EN_TOP),  32'(v & b.top));
    chk({tag, " en_left_b"}, 32'(bus_b.EN_LEFT), 32'(v & b.left));
    chk({tag, " last_b"},    32'(bus_b.last),    32'(v & b.last));
    chk({tag, " done_a"}, 32'(done_a), 32'(d));
    chk({tag, " done_b"}, 32'(done_b), 32'(d));
    chk({tag, " busy_a"}, 32'(busy_a), 32'(bz));
    chk({tag, " busy_b"}, 32'(busy_b), 32'(bz));
  endtask

  task automatic push(input int a, input bit t, input bit l);
    beat_t b;
    b.addr = a; b.top = t; b.left = l; b.last = 1'b0;
    q.push_back(b);
  endtask

  // Expected beat list straight from the fetch-pattern rules.
  task automatic build(input int m, input int pu, input int x, input int y,
                       input int tr, input int bl);
    int n, mm, seg;
    n   = 4 << ((pu > 3) ? 3 : pu);
    mm  = (m == 3) ? 1 : m;
    seg = (mm == 2) ? 2 * n : n;
    q.delete();
    if (mm == 2) push(0, 1'b1, 1'b0);
    for (int i = 0; i < seg; i++) push(x + i, 1'b1, 1'b0);
    if (mm == 0) push(tr, 1'b1, 1'b0);
    for (int i = 0; i < seg; i++) push(y + i, 1'b0, 1'b1);
    if (mm == 0) push(bl, 1'b0, 1'b1);
    q[q.size() - 1].last = 1'b1;
  endtask

  task automatic scramble_inputs();
    logic [31:0] r;
    r = $urandom;
    X = r[5:0]; Y = r[11:6]; mode = r[13:12]; pu_size = r[16:14];
    TR = r[24:17]; BL = r[31:24];
  endtask

  // rdy_pat: 0 always ready, 1 ready on odd cycles, 2 random.
  // junk_at: cycle of a stray start (0 = in the DONE cycle, -1 = none).
  task automatic run_seq(input string tag, input logic [1:0] m, input logic [2:0] pu,
                         input logic [5:0] x, input logic [5:0] y,
                         input logic [7:0] tr, input logic [7:0] bl,
                         input int rdy_pat, input int junk_at,
                         input int abort_at, input int rst_at);
    int k, stalls, nbeats;
    bit done_seen;
    k = 0; stalls = 0; done_seen = 1'b0;
    build(int'(m), int'(pu), int'(x), int'(y), int'(tr), int'(bl));
    nbeats = q.size();
    @(negedge CLK);
    start = 1'b1; abort = 1'b0; mode = m; pu_size = pu; X = x; Y = y; TR = tr; BL = bl;
    while (1) begin
      @(negedge CLK);
      k++;
      start = 1'b0;
      scramble_inputs();
      if (k == junk_at) start = 1'b1;
      if (q.size() != 0) begin
        chk_out(tag, 1'b1, q[0], 1'b0, 1'b1, 1'b0);
        case (rdy_pat)
          0:       rd_ready = 1'b1;
          1:       rd_ready = (k % 2) == 1;
          default: rd_ready = ($urandom_range(0, 1) == 1);
        endcase
        if (k == abort_at) begin
          abort = 1'b1; rd_ready = 1'b1;
          @(negedge CLK);
          abort = 1'b0; start = 1'b0;
          chk_out({tag, " abort"}, 1'b0, zb, 1'b0, 1'b0, 1'b1);
          q.delete();
          for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk_out({tag, " post_abort"}, 1'b0, zb, 1'b0, 1'b0, 1'b0);
          end
          return;
        end
        if (k == rst_at) begin
          #2 RST_n = 1'b0;
          #1 chk_out({tag, " async_rst"}, 1'b0, zb, 1'b0, 1'b0, 1'b1);
          @(negedge CLK);
          RST_n = 1'b1; start = 1'b0;
          q.delete();
          for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk_out({tag, " post_rst"}, 1'b0, zb, 1'b0, 1'b0, 1'b1);
          end
          return;
        end
        if (rd_ready) void'(q.pop_front());
        else stalls++;
      end else if (!done_seen) begin
        chk_out({tag, " done"}, 1'b0, zb, 1'b1, 1'b1, 1'b0);
        chk({tag, " done_cycle"}, 32'(k), 32'(nbeats + stalls + 1));
        done_seen = 1'b1;
        if (junk_at == 0) start = 1'b1;
      end else begin
        chk_out({tag, " idle"}, 1'b0, zb, 1'b0, 1'b0, 1'b0);
        break;
      end
      if (k > 400) begin
        n_cmp++; n_bad++;
        $error("FAIL %s timeout: got cycle %0d expected completion", tag, k);
        break;
      end
    end
    rd_ready = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] r1, r2;
    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk_out("reset", 1'b0, zb, 1'b0, 1'b0, 1'b1);
    RST_n = 1'b1;
    @(negedge CLK);
    chk_out("reset_rel", 1'b0, zb, 1'b0, 1'b0, 1'b1);

    run_seq("planar4",   2'd0, 3'd0, 6'd8,  6'd20, 8'd12,  8'd24,  0, -1, -1, -1);
    run_seq("dc32",      2'd1, 3'd3, 6'd0,  6'd32, 8'd5,   8'd6,   0, -1, -1, -1);
    run_seq("ang8",      2'd2, 3'd1, 6'd40, 6'd50, 8'd7,   8'd9,   0, -1, -1, -1);
    run_seq("backpress", 2'd0, 3'd0, 6'd8,  6'd20, 8'd12,  8'd24,  1, -1, -1, -1);
    run_seq("wrap",      2'd1, 3'd6, 6'd60, 6'd63, 8'd1,   8'd2,   0, -1, -1, -1);
    run_seq("mode3",     2'd3, 3'd1, 6'd17, 6'd3,  8'd200, 8'd250, 2, -1, -1, -1);
    run_seq("ang32",     2'd2, 3'd7, 6'd63, 6'd62, 8'd0,   8'd0,   2, -1, -1, -1);
    run_seq("busy_start",2'd0, 3'd1, 6'd5,  6'd9,  8'd130, 8'd140, 0,  5, -1, -1);
    run_seq("done_start",2'd1, 3'd0, 6'd30, 6'd31, 8'd0,   8'd0,   0,  0, -1, -1);
    run_seq("abort3",    2'd0, 3'd1, 6'd10, 6'd11, 8'd90,  8'd91,  0, -1,  3, -1);
    run_seq("reset_mid", 2'd2, 3'd0, 6'd12, 6'd13, 8'd0,   8'd0,   0, -1, -1,  7);
    run_seq("fresh",     2'd0, 3'd0, 6'd8,  6'd20, 8'd12,  8'd24,  0, -1, -1, -1);

    // abort and start together in IDLE: start is dropped
    @(negedge CLK);
    start = 1'b1; abort = 1'b1;
    @(negedge CLK);
    start = 1'b0; abort = 1'b0;
    chk_out("abort_start_idle", 1'b0, zb, 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 10; r++) begin
      r1 = $urandom;
      r2 = $urandom;
      run_seq("rand", r1[1:0], r1[4:2], r1[10:5], r1[16:11], r1[24:17], r2[7:0],
              2, -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intra_ref_addr_gen.md
# intra_ref_addr_gen

Reference-sample address generator for the intra prediction path. It supports all PU sizes (4/8/16/32) and three fetch patterns: planar, DC, and angular. On a start pulse it latches the block position and emits one neighbour-RAM read address per accepted beat, with top/left/corner bank enables. A valid/ready handshake lets the reference-sample RAM arbiter apply backpressure. It sits between the intra mode controller and the top/left neighbour RAMs.

## Interface
- ADDR_W, 8, neighbour RAM address width
- COORD_W, 6, width of X/Y block coordinates
- CORNER_ADDR, 0, address of the top-left corner sample in the corner/top bank
- CLK  in  1  clock, rising edge
- RST_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; accepted only in IDLE
- abort  in  1  synchronous cancel; has priority over everything except reset
- mode  in  2  0 = planar, 1 = DC, 2 = angular, 3 = treated as DC
- pu_size  in  3  log2 size code: 0=4, 1=8, 2=16, 3=32; codes 4-7 clamp to 32
- X  in  COORD_W  top-row base address
- Y  in  COORD_W  left-column base address
- TOP_RIGHT  in  ADDR_W  top-right sample address (planar)
- BOTTOM_LEFT  in  ADDR_W  bottom-left sample address (planar)
- rd_ready  in  1  downstream accepts current address
- ADDRESS_RAM  out  ADDR_W  read address, registered
- addr_valid  out  1  ADDRESS_RAM is valid this cycle
- EN_TOP  out  1  address targets the top bank (also used for the corner)
- EN_LEFT  out  1  address targets the left bank
- last  out  1  high with the final address of the sequence
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- On start in IDLE, latch mode, N = 4 << min(pu_size, 3), X, Y, TOP_RIGHT and BOTTOM_LEFT. Later input changes do not affect the running sequence.
- States:
  - IDLE
  - CORNER
  - TOP
  - TR
  - LEFT
  - BL
  - DONE
- Sequences by mode:
  - planar: TOP(N) -> TR -> LEFT(N) -> BL; 2N+2 beats.
  - DC: TOP(N) -> LEFT(N); 2N beats.
  - angular: CORNER -> TOP(2N) -> LEFT(2N); 4N+1 beats.
- Addresses per state:
  - TOP emits X+i for i = 0..len-1.
  - LEFT emits Y+i.
  - TR emits TOP_RIGHT; BL emits BOTTOM_LEFT; CORNER emits CORNER_ADDR.
- Arithmetic: zero-extend X/Y to ADDR_W, then add the offset counter (7 bits, max 63). The sum wraps modulo 2^ADDR_W with no error flag.
- Enables:
  - EN_TOP=1 in CORNER, TOP and TR.
  - EN_LEFT=1 in LEFT and BL.
  - Both are 0 whenever addr_valid=0.
- A beat is accepted when addr_valid && rd_ready. Only then do the offset counter and state advance. While not accepted, ADDRESS_RAM, the enables and last hold stable.
- last is high with the final address only.
- After the last beat is accepted: DONE for one cycle (done=1, addr_valid=0), then IDLE.
- start while busy is ignored, including in the DONE cycle.
- abort in any non-IDLE state:
  - next cycle is IDLE with all outputs 0;
  - no done pulse;
  - an in-flight beat presented in the abort cycle counts as not accepted.
- abort and start in the same IDLE cycle: start is ignored.

## Timing
- All outputs are registered. Reset value of every output is 0, including ADDRESS_RAM; FSM resets to IDLE.
- start at cycle t -> first addr_valid, busy=1 at t+1.
- With rd_ready held high, one address per cycle, no bubbles, including across state transitions. Last address at cycle t+beats. done at t+beats+1. busy falls at t+beats+2.
- Minimum start-to-start spacing is beats+2 cycles.
- rd_ready low stretches the sequence one cycle per stalled cycle; the address presented does not change.
- Asynchronous reset mid-sequence: outputs go to 0 immediately, the sequence is discarded, and no done pulse is generated.

## Test plan
- Planar 4x4: X=8, Y=20, TR=12, BL=24, rd_ready=1, start at t.
  - Addresses t+1..t+10 are 8,9,10,11,12,20,21,22,23,24.
  - EN_TOP on the first 5, EN_LEFT on the last 5.
  - last at t+10, done at t+11.
- DC 32x32: X=0, Y=32.
  - 64 beats: 0..31 top, then 32..63 left.
  - last on address 63.
- Angular 8x8, CORNER_ADDR=0: X=40, Y=50.
  - First beat is 0 with EN_TOP.
  - Top 40..55, left 50..65; 33 beats total.
- Backpressure: planar 4x4 with rd_ready low on every other cycle.
  - Each address is held 2 cycles.
  - Sequence identical to the first scenario; done 20 cycles after start.
- Wrap and clamp, with ADDR_W=6: pu_size=6, mode=DC, X=60.
  - Treated as N=32.
  - Top addresses 60,61,62,63,0,1,...
- Control corners:
  - start during busy: ignored.
  - abort on the 3rd beat: next cycle all outputs 0, no done.
  - RST_n low mid-sequence: outputs 0 asynchronously.
  - A fresh start after release produces a full correct sequence.
